// File: rtl/valve_seq_pkg.sv
// Shared build configuration, FSM state and step-record types for the valve PWM sequencer.
// Every file of the block takes its widths from here so the table, interface and generator agree.
package valve_seq_pkg;

  localparam int STEPS  = 8;
  localparam int ADDR_W = $clog2(STEPS);
  localparam int DUTY_W = 8;
  localparam int DUR_W  = 16;

  localparam logic [DUTY_W-1:0] PERIOD_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    logic [DUR_W-1:0]  dur;
  } step_t;

  // Periods still to play after the first one; dur=0 behaves as a single period.
  function automatic logic [DUR_W-1:0] periods_left(input logic [DUR_W-1:0] dur);
    return (dur == '0) ? '0 : dur - DUR_W'(1);
  endfunction

endpackage

// File: rtl/valve_pwm_sequencer_if.sv
// Processor-facing bundle of the sequencer: table write port, playback controls and status.
// master = processor side, slave = sequencer side.
interface valve_pwm_sequencer_if;
  import valve_seq_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DUTY_W-1:0] wr_duty;
  logic [DUR_W-1:0]  wr_dur;
  logic [ADDR_W-1:0] last_step;
  logic              loop_en;
  logic              start;
  logic              abort;
  logic              PWM;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cur_step;

  modport master (
    output wr_en, wr_addr, wr_duty, wr_dur, last_step, loop_en, start, abort,
    input  PWM, busy, done, cur_step
  );

  modport slave (
    input  wr_en, wr_addr, wr_duty, wr_dur, last_step, loop_en, start, abort,
    output PWM, busy, done, cur_step
  );

endinterface

// File: rtl/pwm_gen.sv
// Phase counter plus compare; en and duty describe the coming cycle so PWM is registered with no lag.
// The first enabled cycle is phase 0; period_end flags the last phase of a running period.
module pwm_gen
  import valve_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DUTY_W-1:0] duty,
  output logic              PWM,
  output logic              period_end
);

  logic [DUTY_W-1:0] k;
  logic [DUTY_W-1:0] k_nxt;
  logic              run;

  always_comb begin
    k_nxt = run ? k + DUTY_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k   <= '0;
      run <= 1'b0;
      PWM <= 1'b0;
    end else if (en) begin
      k   <= k_nxt;
      run <= 1'b1;
      PWM <= (k_nxt < duty);
    end else begin
      k   <= '0;
      run <= 1'b0;
      PWM <= 1'b0;
    end
  end

  assign period_end = run && (k == PERIOD_MAX);

endmodule

// File: rtl/valve_pwm_sequencer.sv
// Step-table player: holds (duty, duration) steps and drives one PWM generator through them,
// switching duty only on period boundaries; single-shot or looped, with abort and done pulse.
module valve_pwm_sequencer
  import valve_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  valve_pwm_sequencer_if.slave bus
);

  step_t             tbl [STEPS];
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] step_q, step_d, load_idx;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUR_W-1:0]  left_q, left_d;
  logic              load;
  logic              done_q, done_d;
  logic              period_end;
  logic              pwm;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    duty_d   = duty_q;
    left_d   = left_q;
    done_d   = 1'b0;
    load     = 1'b0;
    load_idx = '0;
    if (state_q == IDLE) begin
      if (bus.start && !bus.abort) begin
        state_d = RUN;
        load    = 1'b1;
      end
    end else if (bus.abort) begin
      state_d = IDLE;
      step_d  = '0;
      duty_d  = '0;
      left_d  = '0;
    end else if (period_end) begin
      if (left_q != '0) begin
        left_d = left_q - DUR_W'(1);
      end else if (step_q != bus.last_step) begin
        load     = 1'b1;
        load_idx = step_q + ADDR_W'(1);
      end else if (bus.loop_en) begin
        load = 1'b1;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
        step_d  = '0;
        duty_d  = '0;
        left_d  = '0;
      end
    end
    // Table read is combinational, so a write landing on the same edge is not seen.
    if (load) begin
      step_d = load_idx;
      duty_d = tbl[load_idx].duty;
      left_d = periods_left(tbl[load_idx].dur);
    end
  end

  pwm_gen u_pwm (
    .clk        (clk),
    .rst        (rst),
    .en         (state_d == RUN),
    .duty       (duty_d),
    .PWM        (pwm),
    .period_end (period_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      duty_q  <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < STEPS; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      duty_q  <= duty_d;
      left_q  <= left_d;
      done_q  <= done_d;
      if (bus.wr_en && state_q == IDLE) begin
        tbl[bus.wr_addr] <= '{duty: bus.wr_duty, dur: bus.wr_dur};
      end
    end
  end

  assign bus.PWM      = pwm;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.cur_step = step_q;

endmodule
